// File: rtl/match_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : match_tracker
//  Purpose  : Match-level bookkeeping behind the reaction-game round logic.
//             Counts round wins and tracks each player's best reaction time.
//             Declares a match winner when a player reaches WINS_TO_MATCH
//             wins, or when MAX_ROUNDS rounds have been played.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock
//    rst          in   synchronous active-high reset
//    round_over   in   level; a rising edge marks one completed round
//    winner       in   [1:0] round winner 00 none / 01 P1 / 10 P2 / 11 tie
//    jump_start   in   round was decided by a false start
//    rt_time      in   [15:0] frozen reaction time, packed BCD
//    new_match    in   single-cycle pulse, clears match state
//    p1_wins      out  [3:0] P1 round wins (binary)
//    p2_wins      out  [3:0] P2 round wins (binary)
//    p1_best      out  [15:0] P1 best time (BCD)
//    p2_best      out  [15:0] P2 best time (BCD)
//    round_count  out  [3:0] rounds completed this match
//    result_valid out  one-cycle pulse after a round is recorded
//    match_over   out  high while the match is finished
//    match_winner out  [1:0] 01 P1 / 10 P2 / 11 draw / 00 in progress
// ============================================================================
module match_tracker #(
    parameter int WINS_TO_MATCH = 3,
    parameter int MAX_ROUNDS    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        round_over,
    input  logic [1:0]  winner,
    input  logic        jump_start,
    input  logic [15:0] rt_time,
    input  logic        new_match,
    output logic [3:0]  p1_wins,
    output logic [3:0]  p2_wins,
    output logic [15:0] p1_best,
    output logic [15:0] p2_best,
    output logic [3:0]  round_count,
    output logic        result_valid,
    output logic        match_over,
    output logic [1:0]  match_winner
);

    localparam logic [0:0]  ST_PLAY       = 1'b0;
    localparam logic [0:0]  ST_MATCH_OVER = 1'b1;

    localparam logic [3:0]  c_wins        = 4'(WINS_TO_MATCH);
    localparam logic [3:0]  c_max_rounds  = 4'(MAX_ROUNDS);
    localparam logic [15:0] c_best_init   = 16'h9999;

    logic [0:0]  state_q,        state_d;
    logic        round_over_q;
    logic [3:0]  p1_wins_q,      p1_wins_d;
    logic [3:0]  p2_wins_q,      p2_wins_d;
    logic [15:0] p1_best_q,      p1_best_d;
    logic [15:0] p2_best_q,      p2_best_d;
    logic [3:0]  round_count_q,  round_count_d;
    logic        result_valid_q, result_valid_d;
    logic [1:0]  match_winner_q, match_winner_d;

    logic        w_edge;
    logic        w_bcd_ok;
    logic        w_time_ok;

    assign w_edge    = round_over & ~round_over_q;
    assign w_bcd_ok  = (rt_time[15:12] <= 4'd9) && (rt_time[11:8] <= 4'd9) &&
                       (rt_time[7:4]   <= 4'd9) && (rt_time[3:0]  <= 4'd9);
    // False starts and corrupt times still count as a win, but never as a time.
    assign w_time_ok = w_bcd_ok & ~jump_start;

    always_comb begin
        state_d        = state_q;
        p1_wins_d      = p1_wins_q;
        p2_wins_d      = p2_wins_q;
        p1_best_d      = p1_best_q;
        p2_best_d      = p2_best_q;
        round_count_d  = round_count_q;
        result_valid_d = 1'b0;
        match_winner_d = match_winner_q;

        if (new_match) begin
            // Overrides any edge arriving in the same cycle.
            state_d        = ST_PLAY;
            p1_wins_d      = 4'd0;
            p2_wins_d      = 4'd0;
            p1_best_d      = c_best_init;
            p2_best_d      = c_best_init;
            round_count_d  = 4'd0;
            match_winner_d = 2'b00;
        end else if ((state_q == ST_PLAY) && w_edge) begin
            result_valid_d = 1'b1;

            if ((winner == 2'b01) && (p1_wins_q != c_wins)) begin
                p1_wins_d = p1_wins_q + 4'd1;
            end
            if ((winner == 2'b10) && (p2_wins_q != c_wins)) begin
                p2_wins_d = p2_wins_q + 4'd1;
            end

            if (round_count_q != 4'hF) begin
                round_count_d = round_count_q + 4'd1;
            end

            // winner[0] covers P1 and tie, winner[1] covers P2 and tie.
            // Unsigned compare orders valid BCD correctly.
            if (w_time_ok) begin
                if (winner[0] && (rt_time < p1_best_q)) begin
                    p1_best_d = rt_time;
                end
                if (winner[1] && (rt_time < p2_best_q)) begin
                    p2_best_d = rt_time;
                end
            end

            // Terminate on the freshly computed counts so the match ends in
            // the same cycle the final result becomes visible.
            if (p1_wins_d == c_wins) begin
                state_d        = ST_MATCH_OVER;
                match_winner_d = 2'b01;
            end else if (p2_wins_d == c_wins) begin
                state_d        = ST_MATCH_OVER;
                match_winner_d = 2'b10;
            end else if (round_count_d == c_max_rounds) begin
                state_d = ST_MATCH_OVER;
                if (p1_wins_d > p2_wins_d) begin
                    match_winner_d = 2'b01;
                end else if (p2_wins_d > p1_wins_d) begin
                    match_winner_d = 2'b10;
                end else begin
                    match_winner_d = 2'b11;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_PLAY;
            round_over_q   <= 1'b0;
            p1_wins_q      <= 4'd0;
            p2_wins_q      <= 4'd0;
            p1_best_q      <= c_best_init;
            p2_best_q      <= c_best_init;
            round_count_q  <= 4'd0;
            result_valid_q <= 1'b0;
            match_winner_q <= 2'b00;
        end else begin
            state_q        <= state_d;
            round_over_q   <= round_over;
            p1_wins_q      <= p1_wins_d;
            p2_wins_q      <= p2_wins_d;
            p1_best_q      <= p1_best_d;
            p2_best_q      <= p2_best_d;
            round_count_q  <= round_count_d;
            result_valid_q <= result_valid_d;
            match_winner_q <= match_winner_d;
        end
    end

    assign p1_wins      = p1_wins_q;
    assign p2_wins      = p2_wins_q;
    assign p1_best      = p1_best_q;
    assign p2_best      = p2_best_q;
    assign round_count  = round_count_q;
    assign result_valid = result_valid_q;
    assign match_over   = (state_q == ST_MATCH_OVER);
    assign match_winner = match_winner_q;

endmodule
`default_nettype wire

// File: tb/tb_match_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_tracker
//  Purpose  : Directed self-checking bench for match_tracker. A default
//             instance (3 wins / 9 rounds) and a short instance (3 wins /
//             4 rounds) share the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_match_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        round_over = 1'b0;
    logic [1:0]  winner = 2'b00;
    logic        jump_start = 1'b0;
    logic [15:0] rt_time = 16'h0000;
    logic        new_match = 1'b0;

    logic [3:0]  p1_wins, p2_wins, round_count;
    logic [15:0] p1_best, p2_best;
    logic        result_valid, match_over;
    logic [1:0]  match_winner;

    logic [3:0]  s_p1_wins, s_p2_wins, s_round_count;
    logic [15:0] s_p1_best, s_p2_best;
    logic        s_result_valid, s_match_over;
    logic [1:0]  s_match_winner;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    match_tracker dut (
        .clk(clk), .rst(rst), .round_over(round_over), .winner(winner),
        .jump_start(jump_start), .rt_time(rt_time), .new_match(new_match),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .p1_best(p1_best),
        .p2_best(p2_best), .round_count(round_count),
        .result_valid(result_valid), .match_over(match_over),
        .match_winner(match_winner)
    );

    match_tracker #(.WINS_TO_MATCH(3), .MAX_ROUNDS(4)) dut_short (
        .clk(clk), .rst(rst), .round_over(round_over), .winner(winner),
        .jump_start(jump_start), .rt_time(rt_time), .new_match(new_match),
        .p1_wins(s_p1_wins), .p2_wins(s_p2_wins), .p1_best(s_p1_best),
        .p2_best(s_p2_best), .round_count(s_round_count),
        .result_valid(s_result_valid), .match_over(s_match_over),
        .match_winner(s_match_winner)
    );

    // One rising edge of round_over, then back low. rv/mo are sampled in the
    // cycle after the edge; rv_after one cycle later (pulse must be gone).
    task automatic round_edge(input logic [1:0] w, input logic js,
                              input logic [15:0] t, output logic rv,
                              output logic mo, output logic rv_after);
        @(negedge clk);
        round_over = 1'b1; winner = w; jump_start = js; rt_time = t;
        @(posedge clk); #1;
        rv = result_valid;
        mo = match_over;
        @(negedge clk);
        round_over = 1'b0; winner = 2'b00; jump_start = 1'b0;
        @(posedge clk); #1;
        rv_after = result_valid;
    endtask

    task automatic pulse_new_match();
        @(negedge clk);
        new_match = 1'b1;
        @(negedge clk);
        new_match = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (p1_best !== 16'h9999 || p2_best !== 16'h9999) begin
            n_bad++;
            $display("FAIL reset_best p1=%h p2=%h want 9999/9999", p1_best, p2_best);
        end
        n_total++;
        if (p1_wins !== 4'd0 || p2_wins !== 4'd0 || round_count !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_counts p1=%0d p2=%0d rc=%0d want 0/0/0", p1_wins, p2_wins, round_count);
        end
        n_total++;
        if (match_over !== 1'b0 || match_winner !== 2'b00 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags mo=%b mw=%b rv=%b want 0/00/0", match_over, match_winner, result_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_p1_match();
        logic rv, mo, rva;
        logic [15:0] times [3];
        times[0] = 16'h0245; times[1] = 16'h0312; times[2] = 16'h0198;
        for (int i = 0; i < 3; i++) begin
            round_edge(2'b01, 1'b0, times[i], rv, mo, rva);
            n_total++;
            if (rv !== 1'b1 || rva !== 1'b0) begin
                n_bad++;
                $display("FAIL p1match_rv round=%0d rv=%b after=%b want 1/0", i, rv, rva);
            end
            n_total++;
            if (mo !== (i == 2)) begin
                n_bad++;
                $display("FAIL p1match_mo round=%0d mo=%b want %b", i, mo, (i == 2));
            end
            if (i == 1) begin
                n_total++;
                if (p1_best !== 16'h0245) begin
                    n_bad++;
                    $display("FAIL p1match_slower best=%h want 0245", p1_best);
                end
            end
        end
        n_total++;
        if (p1_wins !== 4'd3 || p1_best !== 16'h0198 || round_count !== 4'd3 || match_winner !== 2'b01) begin
            n_bad++;
            $display("FAIL p1match_final wins=%0d best=%h rc=%0d mw=%b want 3/0198/3/01",
                     p1_wins, p1_best, round_count, match_winner);
        end
        round_edge(2'b01, 1'b0, 16'h0100, rv, mo, rva);
        n_total++;
        if (rv !== 1'b0 || p1_wins !== 4'd3 || p1_best !== 16'h0198 || round_count !== 4'd3 || mo !== 1'b1) begin
            n_bad++;
            $display("FAIL over_ignore rv=%b wins=%0d best=%h rc=%0d mo=%b want 0/3/0198/3/1",
                     rv, p1_wins, p1_best, round_count, mo);
        end
        pulse_new_match();
        #1;
        n_total++;
        if (match_over !== 1'b0 || match_winner !== 2'b00 || p1_wins !== 4'd0 ||
            p1_best !== 16'h9999 || round_count !== 4'd0) begin
            n_bad++;
            $display("FAIL new_match_clear mo=%b mw=%b wins=%0d best=%h rc=%0d want 0/00/0/9999/0",
                     match_over, match_winner, p1_wins, p1_best, round_count);
        end
    endtask

    task automatic test_jump_start();
        logic rv, mo, rva;
        pulse_new_match();
        round_edge(2'b10, 1'b1, 16'h0000, rv, mo, rva);
        n_total++;
        if (rv !== 1'b1 || rva !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_rv rv=%b after=%b want 1/0", rv, rva);
        end
        n_total++;
        if (p2_wins !== 4'd1 || p2_best !== 16'h9999 || p1_wins !== 4'd0) begin
            n_bad++;
            $display("FAIL jump_state p2w=%0d p2best=%h p1w=%0d want 1/9999/0", p2_wins, p2_best, p1_wins);
        end
    endtask

    task automatic test_tie_and_bad_bcd();
        logic rv, mo, rva;
        pulse_new_match();
        round_edge(2'b11, 1'b0, 16'h0300, rv, mo, rva);
        n_total++;
        if (p1_wins !== 4'd0 || p2_wins !== 4'd0 || p1_best !== 16'h0300 || p2_best !== 16'h0300) begin
            n_bad++;
            $display("FAIL tie p1w=%0d p2w=%0d p1b=%h p2b=%h want 0/0/0300/0300",
                     p1_wins, p2_wins, p1_best, p2_best);
        end
        round_edge(2'b01, 1'b0, 16'h0A12, rv, mo, rva);
        n_total++;
        if (rv !== 1'b1 || p1_wins !== 4'd1 || p1_best !== 16'h0300 || round_count !== 4'd2) begin
            n_bad++;
            $display("FAIL bad_bcd rv=%b p1w=%0d p1b=%h rc=%0d want 1/1/0300/2",
                     rv, p1_wins, p1_best, round_count);
        end
    endtask

    task automatic test_round_limit();
        logic rv, mo, rva;
        logic [1:0] seq_a [4];
        logic [1:0] seq_b [4];
        seq_a[0] = 2'b01; seq_a[1] = 2'b10; seq_a[2] = 2'b00; seq_a[3] = 2'b00;
        seq_b[0] = 2'b01; seq_b[1] = 2'b10; seq_b[2] = 2'b01; seq_b[3] = 2'b00;
        pulse_new_match();
        for (int i = 0; i < 4; i++) begin
            round_edge(seq_a[i], 1'b0, 16'h0500, rv, mo, rva);
            if (i == 2) begin
                n_total++;
                if (s_match_over !== 1'b0) begin
                    n_bad++;
                    $display("FAIL limit_early mo=%b want 0", s_match_over);
                end
            end
        end
        n_total++;
        if (s_match_over !== 1'b1 || s_match_winner !== 2'b11 || s_round_count !== 4'd4) begin
            n_bad++;
            $display("FAIL limit_draw mo=%b mw=%b rc=%0d want 1/11/4", s_match_over, s_match_winner, s_round_count);
        end
        n_total++;
        if (match_over !== 1'b0 || round_count !== 4'd4) begin
            n_bad++;
            $display("FAIL limit_default mo=%b rc=%0d want 0/4", match_over, round_count);
        end
        pulse_new_match();
        for (int i = 0; i < 4; i++) begin
            round_edge(seq_b[i], 1'b0, 16'h0500, rv, mo, rva);
        end
        n_total++;
        if (s_match_over !== 1'b1 || s_match_winner !== 2'b01 || s_p1_wins !== 4'd2 || s_p2_wins !== 4'd1) begin
            n_bad++;
            $display("FAIL limit_leader mo=%b mw=%b p1w=%0d p2w=%0d want 1/01/2/1",
                     s_match_over, s_match_winner, s_p1_wins, s_p2_wins);
        end
    endtask

    task automatic test_new_match_collision();
        logic rv, mo, rva;
        logic seen_rv;
        pulse_new_match();
        @(negedge clk);
        new_match = 1'b1; round_over = 1'b1; winner = 2'b01; rt_time = 16'h0111;
        @(posedge clk); #1;
        n_total++;
        if (result_valid !== 1'b0 || p1_wins !== 4'd0 || round_count !== 4'd0) begin
            n_bad++;
            $display("FAIL collide rv=%b p1w=%0d rc=%0d want 0/0/0", result_valid, p1_wins, round_count);
        end
        @(negedge clk);
        new_match = 1'b0;
        seen_rv = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b0) seen_rv = 1'b1;
        end
        n_total++;
        if (seen_rv !== 1'b0 || p1_wins !== 4'd0) begin
            n_bad++;
            $display("FAIL held_high seen_rv=%b p1w=%0d want 0/0", seen_rv, p1_wins);
        end
        @(negedge clk);
        round_over = 1'b0;
        round_edge(2'b01, 1'b0, 16'h0111, rv, mo, rva);
        n_total++;
        if (rv !== 1'b1 || p1_wins !== 4'd1 || p1_best !== 16'h0111) begin
            n_bad++;
            $display("FAIL rearm rv=%b p1w=%0d best=%h want 1/1/0111", rv, p1_wins, p1_best);
        end
    endtask

    task automatic test_rst_discard();
        @(negedge clk);
        rst = 1'b1; round_over = 1'b1; winner = 2'b10; rt_time = 16'h0050;
        @(posedge clk); #1;
        n_total++;
        if (result_valid !== 1'b0 || p2_wins !== 4'd0 || p1_wins !== 4'd0 || p1_best !== 16'h9999) begin
            n_bad++;
            $display("FAIL rst_edge rv=%b p2w=%0d p1w=%0d p1b=%h want 0/0/0/9999",
                     result_valid, p2_wins, p1_wins, p1_best);
        end
        @(negedge clk);
        rst = 1'b0; round_over = 1'b0;
    endtask

    initial begin
        test_reset();
        test_p1_match();
        test_jump_start();
        test_tie_and_bad_bcd();
        test_round_limit();
        test_new_match_collision();
        test_rst_discard();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_tracker.md
Name: match_tracker

Overview:
Match-level bookkeeping stage directly downstream of the reaction-game round logic. It consumes the per-round result (round_over, winner, jump_start, and the frozen BCD stopwatch time) and maintains round wins and best reaction time per player. It declares a match winner at WINS_TO_MATCH wins or after MAX_ROUNDS rounds. Its outputs feed the display/score path.

Parameters:
WINS_TO_MATCH, 3, round wins needed to take the match; legal range 1..9
MAX_ROUNDS, 9, hard round limit; legal range 1..15; must be >= WINS_TO_MATCH

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
round_over  input  1  level signal from round logic; a rising edge marks one completed round
winner  input  2  round winner, sampled on the edge: 00 none, 01 P1, 10 P2, 11 tie
jump_start  input  1  round was decided by a false start, sampled on the edge
rt_time  input  16  frozen reaction time as packed BCD {sec0, ms2, ms1, ms0}, sampled on the edge
new_match  input  1  single-cycle pulse; clears match state
p1_wins  output  4  P1 round wins, binary
p2_wins  output  4  P2 round wins, binary
p1_best  output  16  P1 best time, packed BCD
p2_best  output  16  P2 best time, packed BCD
round_count  output  4  rounds completed this match
result_valid  output  1  one-cycle pulse when a round has been recorded
match_over  output  1  high while in MATCH_OVER
match_winner  output  2  01 P1, 10 P2, 11 draw, 00 while the match is in progress

Behaviour:
- Reset values: all counters 0, p1_best = p2_best = 16'h9999, result_valid 0, match_over 0, match_winner 00, round_over_q 0, state PLAY.
- Edge detect: round_over_q registers round_over every cycle. edge = round_over & ~round_over_q. new_match does not touch round_over_q, so a held-high round_over never produces a spurious edge.
- FSM states are PLAY and MATCH_OVER.
- PLAY, edge in cycle N: winner, jump_start and rt_time are sampled in cycle N. All outputs update in cycle N+1, and result_valid pulses in cycle N+1.
- Win credit:
  - 01: p1_wins + 1.
  - 10: p2_wins + 1.
  - 11: neither player credited.
  - 00: neither player credited.
- Time recording: occurs only when jump_start = 0 and every nibble of rt_time is <= 9.
  - 01: if rt_time < p1_best, p1_best <= rt_time.
  - 10: the same rule applied to p2_best.
  - 11: both best times updated by the same rule.
  - 00: no time update.
  - Comparison is plain unsigned 16-bit (valid for valid BCD). Equal times leave best unchanged.
- Invalid BCD (any nibble > 9) or jump_start = 1: the win is still credited and no best time changes.
- round_count increments on every recorded edge and saturates at 15. Win counters saturate at WINS_TO_MATCH.
- Transition PLAY -> MATCH_OVER happens in the same cycle (N+1) that the counters reach the terminating condition:
  - p1_wins == WINS_TO_MATCH -> match_winner 01.
  - p2_wins == WINS_TO_MATCH -> match_winner 10.
  - Otherwise, round_count == MAX_ROUNDS -> match_winner is the leader by wins, or 11 if wins are equal.
- MATCH_OVER: edges are ignored; there is no result_valid and no counter change. The block stays in MATCH_OVER until new_match or rst.
- new_match, in either state: next cycle returns to the reset values above, except round_over_q, which keeps tracking round_over.
- new_match and an edge in the same cycle: new_match wins and the edge is discarded (no result_valid).
- rst mid-operation: a pending edge is discarded. rst has priority over everything.

Test Plan:
1. rst for 2 cycles -> p1_best = p2_best = 16'h9999, all counts 0, match_over 0, match_winner 00, result_valid 0.
2. Three edges, winner 01, times 16'h0245, 16'h0312, 16'h0198 -> p1_wins 3, p1_best 16'h0198, round_count 3, match_over 1, match_winner 01 in the cycle after the third edge. A fourth edge -> no result_valid and no change.
3. Edge with winner 10, jump_start 1, rt_time 16'h0000 -> p2_wins 1, p2_best stays 16'h9999, result_valid pulses once.
4. Edge with winner 11, rt_time 16'h0300 -> wins unchanged, p1_best = p2_best = 16'h0300. Next edge, winner 01, rt_time 16'h0A12 (invalid) -> p1_wins 1, p1_best stays 16'h0300.
5. MAX_ROUNDS = 4, WINS_TO_MATCH = 3, winners 01, 10, 00, 00 -> match_over after the 4th edge, match_winner 11. Repeat with winners 01, 10, 01, 00 -> match_winner 01.
6. new_match in the same cycle as an edge (winner 01) -> no result_valid, p1_wins 0. round_over held high afterwards -> no further recording until it falls and rises again.
